ip_lcd_control: RTL and testbench
=================================

IP_LCD_CONTROL -- requirements
Module: ip_lcd_control

Interface
REQ-001 Parameter: CLK_FREQ, default 50_000_000, i_clk frequency in Hz; all delays SHALL derive from it as cycles = CLK_FREQ/1_000_000 * microseconds.
REQ-002 One clock; reset is synchronous and active-low. Ports: i_clk  in  1  rising-edge clock.
REQ-003 i_rst_n  in  1  synchronous active-low reset.
REQ-004 i_data  in  8  operand: cursor position, character code or raw command.
REQ-005 i_func  in  3  request: 0 none, 1 INIT, 2 SETCURSOR, 3 DATA, 4 CMD; 5-7 SHALL be treated as 0.
REQ-006 o_LCD_DATA  out  8  HD44780 data bus.
REQ-007 o_LCD_RW  out  1  read/write select, constant 0 (write-only).
REQ-008 o_LCD_RS  out  1  register select: 0 instruction, 1 data.
REQ-009 o_LCD_E  out  1  enable strobe.
REQ-010 o_LCD_ON, o_LCD_BLON  out  1 each  panel power / backlight, constant 1.
REQ-011 o_valid  out  1  one-cycle pulse when the requested operation has fully completed.

Function
REQ-012 Requests SHALL be level-sampled in IDLE; on acceptance {i_func,i_data} is latched and input changes are ignored until completion.
REQ-013 After completion the FSM SHALL enter DONE and return to IDLE only when i_func==0 or {i_func,i_data} differs from the latched value, so a held request executes once.
REQ-014 Each bus write SHALL follow: drive RS/DATA (E=0) for 2 cycles, E=1 for max(1, 0.5 us) cycles, E=0 hold 2 cycles, then execution wait.
REQ-015 Execution wait SHALL be 2000 us for instruction bytes 0x01, 0x02, 0x03, and 50 us for every other write.
REQ-016 INIT: wait 20000 us with E=0, then write instructions 0x38 (wait 5000 us), 0x38 (wait 200 us), 0x38, 0x38, 0x0C, 0x01, 0x06 using REQ-015 waits; o_valid after the last wait.
REQ-017 SETCURSOR: single instruction write of 0x80 | (i_data[4] ? 0x40 : 0x00) | i_data[3:0]; i_data[7:5] ignored.
REQ-018 DATA: single write with RS=1, DATA=i_data.
REQ-019 CMD: single write with RS=0, DATA=i_data.
REQ-020 o_valid SHALL pulse high exactly one cycle, on the cycle the final execution wait expires; o_LCD_DATA and o_LCD_RS SHALL keep the last written values until the next operation drives new ones.
REQ-021 No automatic initialisation after reset; SETCURSOR/DATA/CMD SHALL be accepted whether or not INIT has run.
REQ-022 FSM states: IDLE, POWER_WAIT, SETUP, E_HIGH, E_HOLD, EXEC_WAIT, DONE; an INIT step index SHALL sequence REQ-016 bytes; single-write functions skip POWER_WAIT.
REQ-023 Delay counter SHALL be wide enough for 20000 us at CLK_FREQ without overflow.

Reset
REQ-024 While i_rst_n==0 at a rising edge: state IDLE, o_LCD_DATA=0x00, o_LCD_RS=0, o_LCD_E=0, o_LCD_RW=0, o_valid=0, o_LCD_ON=1, o_LCD_BLON=1, counters and latched request cleared.
REQ-025 Reset asserted mid-operation SHALL abort immediately; E SHALL be 0 the cycle after the reset edge and no o_valid SHALL be issued for the aborted request.

Verification
REQ-026 Reset with i_func=1, i_data=0x29 held -> all outputs at REQ-024 values, no E activity.
REQ-027 Release reset, i_func=1 -> no E for 20 ms, then seven E pulses carrying 0x38,0x38,0x38,0x38,0x0C,0x01,0x06 with RS=0, then one o_valid pulse; i_func still 1 -> no second sequence.
REQ-028 i_func=2 with i_data 0x00, 0x05, 0x10, 0x15 -> single writes 0x80, 0x85, 0xC0, 0xC5, RS=0, o_valid about 50 us after each E pulse.
REQ-029 i_func=3 with i_data 0x29 then 0x30 -> writes with RS=1, DATA 0x29 then 0x30, RW=0, one o_valid each.
REQ-030 i_func=4 with i_data 0x01 -> RS=0 write, o_valid no earlier than 2000 us after E falls; then i_data 0x06 -> o_valid about 50 us after E.
REQ-031 Assert reset during INIT POWER_WAIT and during E_HIGH -> E=0 next cycle, no o_valid; fresh request afterwards completes normally.

Source files
------------

// File: rtl/ip_lcd_control.sv
// HD44780 character-LCD write controller: INIT sequence, cursor set, data and raw
// command writes, each bus write timed from CLK_FREQ; o_valid pulses on completion.
module ip_lcd_control #(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic [2:0] i_func,
    output logic [7:0] o_LCD_DATA,
    output logic       o_LCD_RW,
    output logic       o_LCD_RS,
    output logic       o_LCD_E,
    output logic       o_LCD_ON,
    output logic       o_LCD_BLON,
    output logic       o_valid
);

    localparam int unsigned CYC_US  = (CLK_FREQ / 1_000_000 == 0) ? 1 : CLK_FREQ / 1_000_000;
    localparam int unsigned T_POWER = CYC_US * 20000;
    localparam int unsigned T_5000  = CYC_US * 5000;
    localparam int unsigned T_2000  = CYC_US * 2000;
    localparam int unsigned T_200   = CYC_US * 200;
    localparam int unsigned T_50    = CYC_US * 50;
    localparam int unsigned T_E     = (CYC_US / 2 == 0) ? 1 : CYC_US / 2;
    localparam int unsigned T_SETUP = 2;
    localparam int unsigned T_HOLD  = 2;
    localparam int unsigned CW      = $clog2(T_POWER + 1);

    localparam logic [2:0] F_NONE   = 3'd0;
    localparam logic [2:0] F_INIT   = 3'd1;
    localparam logic [2:0] F_CURSOR = 3'd2;
    localparam logic [2:0] F_DATA   = 3'd3;

    typedef enum logic [2:0] {
        IDLE,
        POWER_WAIT,
        SETUP,
        E_HIGH,
        E_HOLD,
        EXEC_WAIT,
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    step, step_nxt;
    logic [2:0]    req_func, req_func_nxt;
    logic [7:0]    req_data, req_data_nxt;
    logic [7:0]    lcd_data_nxt;
    logic          lcd_rs_nxt;
    logic          valid_nxt;
    logic [2:0]    func_n;

    assign func_n     = (i_func > 3'd4) ? F_NONE : i_func;
    assign o_LCD_RW   = 1'b0;
    assign o_LCD_ON   = 1'b1;
    assign o_LCD_BLON = 1'b1;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd4:    return 8'h0C;
            3'd5:    return 8'h01;
            3'd6:    return 8'h06;
            default: return 8'h38;
        endcase
    endfunction

    function automatic logic [7:0] single_byte(input logic [2:0] f, input logic [7:0] d);
        if (f == F_CURSOR) return {1'b1, d[4], 2'b00, d[3:0]};
        return d;
    endfunction

    // The first two INIT writes carry their own long settle times; otherwise
    // only clear/home instructions need the slow execution wait.
    function automatic logic [CW-1:0] exec_cycles(input logic is_init, input logic [2:0] idx,
                                                  input logic rs, input logic [7:0] b);
        if (is_init && idx == 3'd0) return CW'(T_5000 - 1);
        if (is_init && idx == 3'd1) return CW'(T_200 - 1);
        if (!rs && (b == 8'h01 || b == 8'h02 || b == 8'h03)) return CW'(T_2000 - 1);
        return CW'(T_50 - 1);
    endfunction

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        step_nxt     = step;
        req_func_nxt = req_func;
        req_data_nxt = req_data;
        lcd_data_nxt = o_LCD_DATA;
        lcd_rs_nxt   = o_LCD_RS;
        valid_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (func_n != F_NONE) begin
                    req_func_nxt = func_n;
                    req_data_nxt = i_data;
                    step_nxt     = '0;
                    if (func_n == F_INIT) begin
                        state_nxt = POWER_WAIT;
                        cnt_nxt   = CW'(T_POWER - 1);
                    end else begin
                        state_nxt    = SETUP;
                        cnt_nxt      = CW'(T_SETUP - 1);
                        lcd_data_nxt = single_byte(func_n, i_data);
                        lcd_rs_nxt   = (func_n == F_DATA);
                    end
                end
            end
            POWER_WAIT: begin
                if (cnt == '0) begin
                    state_nxt    = SETUP;
                    cnt_nxt      = CW'(T_SETUP - 1);
                    lcd_data_nxt = init_byte(3'd0);
                    lcd_rs_nxt   = 1'b0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = E_HIGH;
                    cnt_nxt   = CW'(T_E - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            E_HIGH: begin
                if (cnt == '0) begin
                    state_nxt = E_HOLD;
                    cnt_nxt   = CW'(T_HOLD - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            E_HOLD: begin
                if (cnt == '0) begin
                    state_nxt = EXEC_WAIT;
                    cnt_nxt   = exec_cycles(req_func == F_INIT, step, o_LCD_RS, o_LCD_DATA);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            EXEC_WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (req_func == F_INIT && step != 3'd6) begin
                    step_nxt     = step + 3'd1;
                    state_nxt    = SETUP;
                    cnt_nxt      = CW'(T_SETUP - 1);
                    lcd_data_nxt = init_byte(step + 3'd1);
                    lcd_rs_nxt   = 1'b0;
                end else begin
                    state_nxt = DONE;
                    valid_nxt = 1'b1;
                end
            end
            DONE: begin
                // A held identical request must not re-trigger.
                if (func_n == F_NONE || {func_n, i_data} != {req_func, req_data})
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            step       <= '0;
            req_func   <= '0;
            req_data   <= '0;
            o_LCD_DATA <= '0;
            o_LCD_RS   <= 1'b0;
            o_LCD_E    <= 1'b0;
            o_valid    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            step       <= step_nxt;
            req_func   <= req_func_nxt;
            req_data   <= req_data_nxt;
            o_LCD_DATA <= lcd_data_nxt;
            o_LCD_RS   <= lcd_rs_nxt;
            o_LCD_E    <= (state_nxt == E_HIGH);
            o_valid    <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_ip_lcd_control.sv
// Scoreboard bench for ip_lcd_control: a request model queues the expected bus writes,
// a negedge monitor checks every E pulse, its timing and each o_valid pulse.
module tb_ip_lcd_control;

    localparam int unsigned CLK_FREQ = 2_000_000;
    localparam int unsigned CYC_US   = CLK_FREQ / 1_000_000;
    localparam int unsigned E_CYC    = (CYC_US / 2 == 0) ? 1 : CYC_US / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic [2:0] func = 3'd0;
    logic [7:0] lcd_data;
    logic       lcd_rw, lcd_rs, lcd_e, lcd_on, lcd_blon, valid;

    ip_lcd_control #(.CLK_FREQ(CLK_FREQ)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_data     (data),
        .i_func     (func),
        .o_LCD_DATA (lcd_data),
        .o_LCD_RW   (lcd_rw),
        .o_LCD_RS   (lcd_rs),
        .o_LCD_E    (lcd_e),
        .o_LCD_ON   (lcd_on),
        .o_LCD_BLON (lcd_blon),
        .o_valid    (valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rs;
        bit [7:0]    data;
        int unsigned wait_us;
        int unsigned min_cyc;
        bit          chained;
        bit          last;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned exp_valid = 0;
    int unsigned valid_seen = 0;
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;
    logic [7:0]  init_seq [7] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned exec_us(bit rs, bit [7:0] b);
        return (!rs && b >= 8'h01 && b <= 8'h03) ? 2000 : 50;
    endfunction

    // Reference: what a request should put on the bus, written from the command rules.
    task automatic push_model(input logic [2:0] f, input logic [7:0] d, input int unsigned issue_c);
        wr_t w;
        w.min_cyc = 0;
        w.chained = 1'b0;
        w.last    = 1'b1;
        case (f)
            3'd1: begin
                for (int i = 0; i < 7; i++) begin
                    w.rs      = 1'b0;
                    w.data    = init_seq[i];
                    w.wait_us = (i == 0) ? 5000 : (i == 1) ? 200 : exec_us(1'b0, init_seq[i]);
                    w.min_cyc = (i == 0) ? issue_c + 20000 * CYC_US : 0;
                    w.chained = (i != 0);
                    w.last    = (i == 6);
                    exp_q.push_back(w);
                end
            end
            3'd2: begin
                w.rs   = 1'b0;
                w.data = 8'h80 + (d[4] ? 8'h40 : 8'h00) + (d & 8'h0F);
            end
            3'd3: begin w.rs = 1'b1; w.data = d; end
            3'd4: begin w.rs = 1'b0; w.data = d; end
            default: return;
        endcase
        if (f != 3'd1) begin
            w.wait_us = exec_us(w.rs, w.data);
            exp_q.push_back(w);
        end
        exp_valid++;
    endtask

    int unsigned rise_cyc = 0, fall_cyc = 0, cur_wait = 0;
    bit          e_prev = 0, v_prev = 0, have_fall = 0, cur_last = 0, cur_rs = 0;
    logic [7:0]  cur_data = 8'h00;

    always @(negedge clk) begin
        wr_t w;
        if (rst_n) begin
            if (v_prev) begin
                checks++;
                if (valid !== 1'b0) begin
                    errors++;
                    $display("FAIL valid_width: o_valid=%0b one cycle after pulse, required 0", valid);
                end
            end
            if (lcd_e && !e_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got rs=%0b data=0x%02h, required no E pulse", lcd_rs, lcd_data);
                end else begin
                    w = exp_q.pop_front();
                    if ({lcd_rs, lcd_data, lcd_rw} !== {w.rs, w.data, 1'b0}) begin
                        errors++;
                        $display("FAIL write: got rs=%0b data=0x%02h rw=%0b, required rs=%0b data=0x%02h rw=0",
                                 lcd_rs, lcd_data, lcd_rw, w.rs, w.data);
                    end
                    if (w.min_cyc != 0) begin
                        checks++;
                        if (cyc < w.min_cyc || cyc > w.min_cyc + 6) begin
                            errors++;
                            $display("FAIL power_wait: first E at cycle %0d, required %0d..%0d", cyc, w.min_cyc, w.min_cyc + 6);
                        end
                    end
                    if (w.chained) begin
                        checks++;
                        if (!have_fall || cyc - fall_cyc < cur_wait || cyc - fall_cyc > cur_wait + 6) begin
                            errors++;
                            $display("FAIL exec_gap: gap %0d cycles, required %0d..%0d", cyc - fall_cyc, cur_wait, cur_wait + 6);
                        end
                    end
                    cur_wait = w.wait_us * CYC_US;
                    cur_last = w.last;
                    cur_rs   = w.rs;
                    cur_data = w.data;
                end
                rise_cyc  = cyc;
                have_fall = 0;
            end
            if (!lcd_e && e_prev) begin
                checks++;
                if (cyc - rise_cyc != E_CYC) begin
                    errors++;
                    $display("FAIL e_width: E high %0d cycles, required %0d", cyc - rise_cyc, E_CYC);
                end
                fall_cyc  = cyc;
                have_fall = 1;
            end
            if (valid) begin
                checks++;
                if (exp_valid == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: o_valid=1 at cycle %0d, required 0", cyc);
                end else begin
                    exp_valid--;
                    if (!cur_last || !have_fall || cyc - fall_cyc < cur_wait || cyc - fall_cyc > cur_wait + 4) begin
                        errors++;
                        $display("FAIL valid_timing: %0d cycles after E fall (last=%0b), required %0d..%0d",
                                 cyc - fall_cyc, cur_last, cur_wait, cur_wait + 4);
                    end
                    checks++;
                    if ({lcd_rs, lcd_data} !== {cur_rs, cur_data}) begin
                        errors++;
                        $display("FAIL bus_hold: rs=%0b data=0x%02h at o_valid, required rs=%0b data=0x%02h",
                                 lcd_rs, lcd_data, cur_rs, cur_data);
                    end
                end
                valid_seen++;
                cur_last = 0;
            end
        end
        e_prev = lcd_e;
        v_prev = valid;
    end

    task automatic issue(input logic [2:0] f, input logic [7:0] d, input int unsigned hold, input bit release_it);
        int unsigned start_seen;
        int unsigned budget;
        @(posedge clk);
        #1;
        push_model(f, d, cyc);
        func = f;
        data = d;
        start_seen = valid_seen;
        if (f >= 3'd1 && f <= 3'd4) begin
            budget = (f == 3'd1) ? 30000 * CYC_US : 2200 * CYC_US;
            for (int unsigned i = 0; i < budget && valid_seen == start_seen; i++) @(posedge clk);
            if (valid_seen == start_seen) begin
                errors++;
                checks++;
                $display("FAIL timeout: func=%0d data=0x%02h got no o_valid, required one", f, d);
                exp_q.delete();
                exp_valid = 0;
            end
        end
        repeat (hold) @(posedge clk);
        if (release_it) begin
            #1;
            func = 3'd0;
            repeat (2) @(posedge clk);
        end
    endtask

    task automatic abort_reset(input int unsigned n);
        rst_n = 1'b0;
        exp_q.delete();
        exp_valid = 0;
        have_fall = 0;
        cur_last  = 0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({lcd_e, valid} !== 2'b00) begin
            errors++;
            $display("FAIL abort: E=%0b valid=%0b after reset edge, required 0 0", lcd_e, valid);
        end
        repeat (n) @(posedge clk);
        #1;
        func  = 3'd0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        func  = 3'd1;
        data  = 8'h29;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({lcd_data, lcd_rs, lcd_e, lcd_rw, valid, lcd_on, lcd_blon} !== {8'h00, 5'b00000, 2'b11}) begin
                errors++;
                $display("FAIL reset_state: data=0x%02h rs=%0b e=%0b rw=%0b valid=%0b on=%0b blon=%0b, required 00 0 0 0 0 1 1",
                         lcd_data, lcd_rs, lcd_e, lcd_rw, valid, lcd_on, lcd_blon);
            end
        end
        @(posedge clk);
        #1;
        func  = 3'd0;
        rst_n = 1'b1;

        issue(3'd1, 8'h29, 300, 1'b1);
        foreach (init_seq[i]) begin end
        issue(3'd2, 8'h00, 5, 1'b1);
        issue(3'd2, 8'h05, 5, 1'b1);
        issue(3'd2, 8'h10, 5, 1'b1);
        issue(3'd2, 8'h15, 5, 1'b1);
        issue(3'd3, 8'h29, 5, 1'b0);
        issue(3'd3, 8'h30, 5, 1'b1);
        issue(3'd4, 8'h01, 5, 1'b1);
        issue(3'd4, 8'h06, 5, 1'b1);

        @(posedge clk);
        #1;
        push_model(3'd1, 8'h00, cyc);
        func = 3'd1;
        repeat (100) @(posedge clk);
        #1;
        abort_reset(3);

        @(posedge clk);
        #1;
        push_model(3'd3, 8'h55, cyc);
        func = 3'd3;
        data = 8'h55;
        begin
            int unsigned k;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!lcd_e && k < 20);
            if (!lcd_e) begin
                errors++;
                checks++;
                $display("FAIL timeout: no E pulse for abort write within %0d cycles, required one", k);
            end
        end
        abort_reset(3);
        issue(3'd3, 8'hA7, 5, 1'b1);

        for (int n = 0; n < 12; n++) begin
            logic [2:0] f;
            logic [7:0] d;
            f = 3'($urandom_range(7, 2));
            d = 8'($urandom);
            issue(f, d, 8, 1'b1);
        end

        repeat (20) @(posedge clk);
        checks++;
        if (exp_q.size() != 0 || exp_valid != 0) begin
            errors++;
            $display("FAIL drain: %0d writes and %0d o_valid still expected, required 0 0", exp_q.size(), exp_valid);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded 150000 cycles, required completion");
        $fatal(1, "watchdog");
    end

endmodule
